// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480@60) and the per-axis phase decode.
package vga_timing_pkg;

  // Horizontal phase lengths in pixels.
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;

  // Vertical phase lengths in lines.
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL =
      VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
      VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Position of an axis counter within its line or frame.
  typedef enum logic [1:0] {
    PhaseVisible,
    PhaseFront,
    PhaseSync,
    PhaseBack
  } phase_e;

  // Map a counter position onto its phase; everything past sync is back porch.
  function automatic phase_e phase_of(input int unsigned pos,
                                      input int unsigned visible,
                                      input int unsigned front,
                                      input int unsigned sync_len);
    phase_e ph;
    if (pos < visible) begin
      ph = PhaseVisible;
    end else if (pos < visible + front) begin
      ph = PhaseFront;
    end else if (pos < visible + front + sync_len) begin
      ph = PhaseSync;
    end else begin
      ph = PhaseBack;
    end
    return ph;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap chaining, phase decode and raw sync.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW      = 10,
  parameter int unsigned VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned FRONT   = VGA_H_FRONT,
  parameter int unsigned SYNC    = VGA_H_SYNC,
  parameter int unsigned BACK    = VGA_H_BACK
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          wrap_in,
  output logic [CW-1:0] count,
  output phase_e        phase,
  output logic          wrap_out,
  output logic          sync_n
);

  localparam int unsigned   TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

  logic [CW-1:0] count_q, count_d;
  logic          step;
  logic          at_last;

  assign step     = enable & wrap_in;
  assign at_last  = (count_q == LAST);
  // Only reported on the step that actually wraps, so the next axis can chain on it.
  assign wrap_out = step & at_last;

  // Next position: advance on a step, return to zero after the final position.
  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Phase and sync are pure decodes of the current position.
  always_comb begin
    phase  = phase_of(32'(count_q), VISIBLE, FRONT, SYNC);
    sync_n = (phase != PhaseSync);
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate strobe, h/v counters, registered visible-area
// outputs and sync outputs delayed to match the colour stage register latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned C_SIZE    = 9,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned SYNC_DLY  = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          pixel_tick,
  output logic [C_SIZE:0] row,
  output logic [C_SIZE:0] column,
  output logic          disp_enable,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  localparam int unsigned CW       = C_SIZE + 1;
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

  // Tick divider state.
  logic [3:0] div_q, div_d;
  logic       tick_q;

  // Axis counter outputs.
  logic [CW-1:0] h_count, v_count;
  phase_e        h_phase, v_phase;
  logic          h_wrap, v_wrap;
  logic          h_sync_n, v_sync_n;

  // Registered visible-area outputs.
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] column_q, column_d;
  logic          disp_enable_q, disp_enable_d;
  logic          frame_wrap_q;
  logic          frame_start_q;

  // Stage 0 aligns sync with the registered outputs; further stages add SYNC_DLY.
  logic [SYNC_DLY:0] hsync_pipe_q;
  logic [SYNC_DLY:0] vsync_pipe_q;

  // Divider next state: count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
  end

  // Divider and strobe; the strobe is registered, so it rises on the clock after the wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_q == DIV_LAST);
    end
  end

  vga_axis_counter #(
    .CW      (CW),
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (tick_q),
    .wrap_in  (1'b1),
    .count    (h_count),
    .phase    (h_phase),
    .wrap_out (h_wrap),
    .sync_n   (h_sync_n)
  );

  vga_axis_counter #(
    .CW      (CW),
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (tick_q),
    .wrap_in  (h_wrap),
    .count    (v_count),
    .phase    (v_phase),
    .wrap_out (v_wrap),
    .sync_n   (v_sync_n)
  );

  // Visible-area decode; row/column are forced to zero outside it.
  always_comb begin
    disp_enable_d = (h_phase == PhaseVisible) && (v_phase == PhaseVisible);
    row_d         = disp_enable_d ? v_count : '0;
    column_d      = disp_enable_d ? h_count : '0;
  end

  // Output registers, one clock behind the counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q         <= '0;
      column_q      <= '0;
      disp_enable_q <= 1'b0;
      frame_wrap_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      row_q         <= row_d;
      column_q      <= column_d;
      disp_enable_q <= disp_enable_d;
      // Counters land on (0,0) the clock after the joint wrap; flag it one clock later.
      frame_wrap_q  <= v_wrap;
      frame_start_q <= frame_wrap_q;
    end
  end

  // Sync delay line; every stage resets to the inactive (high) level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync_pipe_q <= '1;
      vsync_pipe_q <= '1;
    end else begin
      hsync_pipe_q[0] <= h_sync_n;
      vsync_pipe_q[0] <= v_sync_n;
      for (int i = 1; i <= int'(SYNC_DLY); i++) begin
        hsync_pipe_q[i] <= hsync_pipe_q[i-1];
        vsync_pipe_q[i] <= vsync_pipe_q[i-1];
      end
    end
  end

  assign pixel_tick  = tick_q;
  assign row         = row_q;
  assign column      = column_q;
  assign disp_enable = disp_enable_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_pipe_q[SYNC_DLY];
  assign vsync       = vsync_pipe_q[SYNC_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries checked every clock against a
// closed-form model of elapsed clocks since reset release, plus measured
// periods/widths and randomized mid-frame resets.
module tb_vga_timing_gen;

  localparam int unsigned C_SIZE = 9;

  // A: default 640x480 timing.
  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_DIV = 2, A_DLY = 1;
  // B: tiny geometry with a slow strobe.
  localparam int B_HV = 4, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_DIV = 3, B_DLY = 1;
  // C: one pixel per clock, deeper sync delay.
  localparam int C_HV = 20, C_HF = 2, C_HS = 3, C_HB = 5;
  localparam int C_VV = 12, C_VF = 1, C_VS = 2, C_VB = 2;
  localparam int C_DIV = 1, C_DLY = 2;

  localparam int CNT_RANGE = 1 << (C_SIZE + 1);

  if ((A_HV + A_HF + A_HS + A_HB) > CNT_RANGE || (A_VV + A_VF + A_VS + A_VB) > CNT_RANGE ||
      (B_HV + B_HF + B_HS + B_HB) > CNT_RANGE || (B_VV + B_VF + B_VS + B_VB) > CNT_RANGE ||
      (C_HV + C_HF + C_HS + C_HB) > CNT_RANGE || (C_VV + C_VF + C_VS + C_VB) > CNT_RANGE)
  begin : g_width_chk
    $error("raster total exceeds counter range");
  end

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, div, dly;
  } geo_t;

  typedef struct packed {
    logic       tick;
    logic [9:0] row;
    logic [9:0] column;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       pt_a, de_a, hs_a, vs_a, fs_a;
  logic [9:0] row_a, col_a;
  logic       pt_b, de_b, hs_b, vs_b, fs_b;
  logic [9:0] row_b, col_b;
  logic       pt_c, de_c, hs_c, vs_c, fs_c;
  logic [9:0] row_c, col_c;

  vga_timing_gen #(
    .C_SIZE(C_SIZE), .CLK_DIV(A_DIV),
    .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
    .SYNC_DLY(A_DLY)
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .pixel_tick(pt_a), .row(row_a), .column(col_a),
    .disp_enable(de_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .C_SIZE(C_SIZE), .CLK_DIV(B_DIV),
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .SYNC_DLY(B_DLY)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .pixel_tick(pt_b), .row(row_b), .column(col_b),
    .disp_enable(de_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .C_SIZE(C_SIZE), .CLK_DIV(C_DIV),
    .H_VISIBLE(C_HV), .H_FRONT(C_HF), .H_SYNC(C_HS), .H_BACK(C_HB),
    .V_VISIBLE(C_VV), .V_FRONT(C_VF), .V_SYNC(C_VS), .V_BACK(C_VB),
    .SYNC_DLY(C_DLY)
  ) u_dut_c (
    .clock(clock), .reset_n(reset_n), .pixel_tick(pt_c), .row(row_c), .column(col_c),
    .disp_enable(de_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  geo_t geo_a, geo_b, geo_c;
  int   k = 0;          // clock edges seen since reset release
  bit   check_en = 1'b0;
  bit   meas_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Pixel steps completed by edge n: the first strobe appears after edge div and
  // every later strobe div edges apart; each strobe advances the raster on the next edge.
  function automatic int pix(input int n, input int div);
    return (n <= 0) ? 0 : (n - 1) / div;
  endfunction

  function automatic obs_t model(input geo_t g, input int kk);
    obs_t o;
    int ht, vt, p, h, v, j;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    o.tick = (kk >= 1) && (kk % g.div == 0);
    if (kk >= 1) begin
      p = pix(kk - 1, g.div);
      h = p % ht;
      v = (p / ht) % vt;
      o.de = (h < g.hv) && (v < g.vv);
      if (o.de) begin
        o.row    = 10'(v);
        o.column = 10'(h);
      end
    end
    if (kk >= 2) begin
      o.fs = (pix(kk - 1, g.div) != pix(kk - 2, g.div)) &&
             (pix(kk - 1, g.div) % (ht * vt) == 0);
    end
    j = kk - g.dly;
    if (j >= 1) begin
      p = pix(j - 1, g.div);
      h = p % ht;
      v = (p / ht) % vt;
      o.hs = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
      o.vs = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
    end
    return o;
  endfunction

  task automatic check_inst(input string id, input geo_t g, input int kk,
                            input logic tick, input logic [9:0] row, input logic [9:0] col,
                            input logic de, input logic hs, input logic vs, input logic fs);
    obs_t e;
    e = model(g, kk);
    check_eq({id, ".pixel_tick"}, 32'(tick), 32'(e.tick));
    check_eq({id, ".row"}, 32'(row), 32'(e.row));
    check_eq({id, ".column"}, 32'(col), 32'(e.column));
    check_eq({id, ".disp_enable"}, 32'(de), 32'(e.de));
    check_eq({id, ".hsync"}, 32'(hs), 32'(e.hs));
    check_eq({id, ".vsync"}, 32'(vs), 32'(e.vs));
    check_eq({id, ".frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  // Measurement trackers (times in clocks).
  int   cyc = 0;
  int   a_fall_t = -1, a_defall_t = -1, a_run = 0;
  bit   a_de_seen = 1'b0;
  int   a_lastcol = 0;
  int   b_hfall_t = -1, b_vfall_t = -1;
  int   c_fs_t = -1;
  logic prev_hs_a = 1'b1, prev_de_a = 1'b0;
  logic prev_hs_b = 1'b1, prev_vs_b = 1'b1, prev_fs_c = 1'b0;

  always @(negedge clock) begin
    if (check_en) begin
      check_inst("A", geo_a, k, pt_a, row_a, col_a, de_a, hs_a, vs_a, fs_a);
      check_inst("B", geo_b, k, pt_b, row_b, col_b, de_b, hs_b, vs_b, fs_b);
      check_inst("C", geo_c, k, pt_c, row_c, col_c, de_c, hs_c, vs_c, fs_c);
    end
    if (meas_en) begin
      cyc++;
      // A: line period, sync width, visible run and visible-end to sync offset.
      if (prev_hs_a && !hs_a) begin
        if (a_fall_t >= 0)   check_eq("A.hs_period", cyc - a_fall_t, A_DIV * 800);
        if (a_defall_t >= 0) check_eq("A.de_to_hs", cyc - a_defall_t, A_DIV * A_HF + A_DLY);
        a_fall_t = cyc;
      end
      if (!prev_hs_a && hs_a && a_fall_t >= 0) check_eq("A.hs_low", cyc - a_fall_t, A_DIV * A_HS);
      if (de_a) begin
        a_run++;
        a_lastcol = int'(col_a);
      end
      if (prev_de_a && !de_a) begin
        // The first line after release holds pixel 0 for one extra clock.
        if (a_de_seen) check_eq("A.de_run", a_run, A_DIV * A_HV);
        check_eq("A.last_col", a_lastcol, A_HV - 1);
        a_de_seen = 1'b1;
        a_run = 0;
        a_defall_t = cyc;
      end
      // B: sync widths on the tiny geometry.
      if (prev_hs_b && !hs_b) b_hfall_t = cyc;
      if (!prev_hs_b && hs_b && b_hfall_t >= 0) check_eq("B.hs_low", cyc - b_hfall_t, B_DIV * B_HS);
      if (prev_vs_b && !vs_b) b_vfall_t = cyc;
      if (!prev_vs_b && vs_b && b_vfall_t >= 0)
        check_eq("B.vs_low", cyc - b_vfall_t, B_DIV * B_VS * (B_HV + B_HF + B_HS + B_HB));
      // C: frame pulse spacing and coincidence with the first visible pixel.
      if (fs_c) begin
        check_eq("C.fs_single", 32'(prev_fs_c), 0);
        check_eq("C.fs_row", 32'(row_c), 0);
        check_eq("C.fs_col", 32'(col_c), 0);
        check_eq("C.fs_de", 32'(de_c), 1);
        if (c_fs_t >= 0)
          check_eq("C.fs_period", cyc - c_fs_t,
                   C_DIV * (C_HV + C_HF + C_HS + C_HB) * (C_VV + C_VF + C_VS + C_VB));
        c_fs_t = cyc;
      end
    end
    prev_hs_a = hs_a;
    prev_de_a = de_a;
    prev_hs_b = hs_b;
    prev_vs_b = vs_b;
    prev_fs_c = fs_c;
  end

  initial begin
    int  n;
    bit  found;
    geo_a = '{A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_DIV, A_DLY};
    geo_b = '{B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_DIV, B_DLY};
    geo_c = '{C_HV, C_HF, C_HS, C_HB, C_VV, C_VF, C_VS, C_VB, C_DIV, C_DLY};
    reset_n = 1'b0;

    repeat (3) @(posedge clock);
    check_en = 1'b1;
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    meas_en = 1'b1;

    // First strobe on the default instance, bounded wait.
    n = 0;
    found = 1'b0;
    while (!found && n < 10) begin
      @(posedge clock);
      #1;
      n++;
      if (pt_a) found = 1'b1;
    end
    check_eq("A.first_tick", n, A_DIV);

    repeat (14000) @(posedge clock);
    meas_en = 1'b0;

    // Randomized mid-frame resets: outputs must drop with no clock, then restart cleanly.
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(100, 1500)) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check_inst("A.async", geo_a, 0, pt_a, row_a, col_a, de_a, hs_a, vs_a, fs_a);
      check_inst("B.async", geo_b, 0, pt_b, row_b, col_b, de_b, hs_b, vs_b, fs_b);
      check_inst("C.async", geo_c, 0, pt_c, row_c, col_c, de_c, hs_c, vs_c, fs_c);
      repeat ($urandom_range(1, 4)) @(posedge clock);
      @(negedge clock);
      #2;
      reset_n = 1'b1;
    end

    repeat (600) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
